// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares one single-port data memory between the CPU load/store port (m0)
// and the debug/loader port (m1). The CPU has fixed priority, but m1 takes
// priority once it has been denied STARVE_LIMIT cycles in a row. The grant
// is combinational. A load's response is delivered exactly one cycle after
// its grant and goes back to the requester that owns it.
//
// Ports
//   clk, reset                : clock; synchronous active-low reset
//   m0_* (req/we/addr/wdata/wstrb -> gnt/rvalid/rdata/stall) : CPU port
//   m1_* (req/we/addr/wdata/wstrb -> gnt/rvalid/rdata)       : debug port
//   mem_en/we/addr/wdata/wstrb: memory request side
//   mem_rdata                 : memory read data, one cycle after a read
//   err                       : misaligned-access pulse
//
// Build option
//   DMEM_ARB_MISALIGN_CHK_EN  : when defined, misaligned accesses are still
//                               granted but do not reach memory. err pulses
//                               in the next cycle, and a misaligned load
//                               returns zero data. When undefined, err is
//                               always 0.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  output logic                  m0_stall,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  output logic                  err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        resp_pending_q, resp_pending_d;
  logic        rd_owner_q, rd_owner_d;     // 0 = m0, 1 = m1
  logic        rd_zero_q, rd_zero_d;       // response must return zero data
  logic        err_q, err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic                  pri1;
  logic                  any_gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [3:0]            sel_wstrb;
  logic                  misaligned;
  logic [31:0]           resp_data;

  // Grant, request mux and memory drive
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    pri1   = (starve_cnt_q == LIMIT);
    if (reset) begin
      if (pri1 && m1_req)  m1_gnt = 1'b1;
      else if (m0_req)     m0_gnt = 1'b1;
      else if (m1_req)     m1_gnt = 1'b1;
    end
    any_gnt   = m0_gnt | m1_gnt;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    sel_wstrb = m1_gnt ? m1_wstrb : m0_wstrb;
  end

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  logic [3:0] below_off;  // byte lanes below the address offset
  always_comb begin
    below_off  = ~(4'hF << sel_addr[1:0]);
    misaligned = 1'b0;
    if (any_gnt && (sel_addr[1:0] != 2'b00)) begin
      // A store whose strobes all sit at or above the offset stays inside
      // one word. A load with any offset is misaligned.
      misaligned = sel_we ? ((sel_wstrb & below_off) != 4'h0) : 1'b1;
    end
  end
`else
  always_comb misaligned = 1'b0;
`endif

  always_comb begin
    mem_en    = any_gnt & ~misaligned;
    mem_we    = mem_en & sel_we;
    mem_addr  = any_gnt ? sel_addr : '0;
    mem_wdata = any_gnt ? sel_wdata : 32'h0;
    mem_wstrb = mem_we ? sel_wstrb : 4'h0;
    m0_stall  = m0_req & ~m0_gnt;
  end

  // Response steering. rvalid is also gated by reset so that a response
  // pending when reset arrives is never shown to a requester.
  always_comb begin
    m0_rvalid  = reset & resp_pending_q & ~rd_owner_q;
    m1_rvalid  = reset & resp_pending_q & rd_owner_q;
    resp_data  = rd_zero_q ? 32'h0 : mem_rdata;
    m0_rdata   = m0_rvalid ? resp_data : m0_rdata_q;
    m1_rdata   = m1_rvalid ? resp_data : m1_rdata_q;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
    err        = err_q;
  end

  // Next-state logic
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req || m1_gnt)      starve_cnt_d = 4'h0;
    else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'h1;
    resp_pending_d = any_gnt & ~sel_we;
    rd_owner_d     = m1_gnt;
    rd_zero_d      = misaligned;
    err_d          = misaligned;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt_q   <= 4'h0;
      resp_pending_q <= 1'b0;
      rd_owner_q     <= 1'b0;
      rd_zero_q      <= 1'b0;
      err_q          <= 1'b0;
      m0_rdata_q     <= 32'h0;
      m1_rdata_q     <= 32'h0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      resp_pending_q <= resp_pending_d;
      rd_owner_q     <= rd_owner_d;
      rd_zero_q      <= rd_zero_d;
      err_q          <= err_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_gnt, m0_rvalid, m0_stall;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .err(err)
  );

  // Small single-port memory: 16 words, byte strobes, one-cycle read
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[5:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    m0_req = 1; m1_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_gnt); end
    n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_gnt); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    n_checks++; if ({m0_rvalid, m1_rvalid, err} !== 3'b000) begin n_fail++; $display("FAIL reset_regs got=%b exp=000", {m0_rvalid, m1_rvalid, err}); end
    step();
    reset = 1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if ({m0_rvalid, m1_rvalid, err} !== 3'b000) begin n_fail++; $display("FAIL post_reset_regs got=%b exp=000", {m0_rvalid, m1_rvalid, err}); end
    n_checks++; if ({mem_en, mem_we, mem_wstrb} !== 6'b0) begin n_fail++; $display("FAIL idle_mem got=%b exp=000000", {mem_en, mem_we, mem_wstrb}); end
    $display("test_reset done");
  endtask

  task automatic test_single_load();
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL load_gnt got=%b exp=1", m0_gnt); end
    n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL load_mem_en_we got=%b%b exp=10", mem_en, mem_we); end
    n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL load_addr got=%h exp=00000010", mem_addr); end
    n_checks++; if (m0_stall !== 1'b0) begin n_fail++; $display("FAIL load_stall got=%b exp=0", m0_stall); end
    step();
    m0_req = 0;
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL load_rvalid got=%b exp=1", m0_rvalid); end
    n_checks++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata got=%h exp=deadbeef", m0_rdata); end
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_m1_rvalid got=%b exp=0", m1_rvalid); end
    step();
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_rvalid_once got=%b exp=0", m0_rvalid); end
    n_checks++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_hold got=%h exp=deadbeef", m0_rdata); end
    $display("test_single_load: m0 load 0x10 done");
  endtask

  task automatic test_contention();
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    m1_req = 1; m1_we = 0; m1_addr = 32'h24;
    for (int i = 0; i < 10; i++) begin
      logic exp_m1;
      exp_m1 = ((i % 5) == 4);
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt, m0_stall} !== {~exp_m1, exp_m1, exp_m1}) begin
        n_fail++;
        $display("FAIL contention_cyc%0d got gnt0/gnt1/stall=%b exp=%b", i,
                 {m0_gnt, m1_gnt, m0_stall}, {~exp_m1, exp_m1, exp_m1});
      end
      step();
    end
    idle_inputs();
    $display("test_contention: 10 cycles done");
  endtask

  task automatic test_store_then_load();
    step();
    m1_req = 1; m1_we = 1; m1_addr = 32'h0; m1_wdata = 32'hC0DECAFE; m1_wstrb = 4'hF;
    @(negedge clk);
    n_checks++; if (m1_gnt !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL store_gnt_we got=%b%b exp=11", m1_gnt, mem_we); end
    n_checks++; if (mem_wdata !== 32'hC0DECAFE || mem_wstrb !== 4'hF) begin n_fail++; $display("FAIL store_data got=%h/%h exp=c0decafe/f", mem_wdata, mem_wstrb); end
    step();
    idle_inputs();
    m0_req = 1; m0_addr = 32'h0;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL sl_load_gnt got=%b exp=1", m0_gnt); end
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_no_rvalid got=%b exp=0", m1_rvalid); end
    step();
    m0_req = 0;
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hC0DECAFE) begin n_fail++; $display("FAIL sl_load_data got=%b/%h exp=1/c0decafe", m0_rvalid, m0_rdata); end
    $display("test_store_then_load done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [0:2];
    exp_data[0] = 32'h11111111; exp_data[1] = 32'h22222222; exp_data[2] = 32'h33333333;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 3) begin m0_req = 1; m0_we = 0; m0_addr = 32'(4 * (k + 1)); end
      else m0_req = 0;
      @(negedge clk);
      if (k < 3) begin
        n_checks++; if (m0_gnt !== 1'b1 || m0_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_gnt%0d got gnt/stall=%b%b exp=10", k, m0_gnt, m0_stall); end
      end
      if (k >= 1) begin
        n_checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== exp_data[k-1]) begin
          n_fail++; $display("FAIL b2b_resp%0d got=%b/%h exp=1/%h", k - 1, m0_rvalid, m0_rdata, exp_data[k-1]);
        end
      end
    end
    $display("test_back_to_back: 3 loads done");
  endtask

  task automatic test_reset_mid();
    step();
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    @(negedge clk);
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt got=%b exp=1", m1_gnt); end
    step();
    m1_req = 0; reset = 0;
    @(negedge clk);
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid got=%b exp=0", m1_rvalid); end
    step();
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid, err} !== 6'b0) begin
      n_fail++; $display("FAIL rmid_outputs got=%b exp=000000", {m0_gnt, m1_gnt, mem_en, m0_rvalid, m1_rvalid, err});
    end
    step();
    reset = 1;
    @(negedge clk);
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_discard got=%b exp=0", m1_rvalid); end
    $display("test_reset_mid done");
  endtask

  task automatic test_wstrb_zero();
    step();
    m0_req = 1; m0_we = 1; m0_addr = 32'h8; m0_wdata = 32'hFFFFFFFF; m0_wstrb = 4'h0;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, mem_en, mem_we, mem_wstrb} !== 7'b1110000) begin
      n_fail++; $display("FAIL wstrb0 got=%b exp=1110000", {m0_gnt, mem_en, mem_we, mem_wstrb});
    end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL wstrb0_no_rvalid got=%b exp=0", m0_rvalid); end
    $display("test_wstrb_zero done");
  endtask

  task automatic test_misalign();
    step();
    m0_req = 1; m0_we = 1; m0_addr = 32'h2; m0_wdata = 32'h12345678; m0_wstrb = 4'hF;
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL mis_gnt got=%b exp=1", m0_gnt); end
    n_checks++; if (mem_en !== ~CHK) begin n_fail++; $display("FAIL mis_mem_en got=%b exp=%b", mem_en, ~CHK); end
    step();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (err !== CHK) begin n_fail++; $display("FAIL mis_err got=%b exp=%b", err, CHK); end
    step();
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mis_err_pulse got=%b exp=0", err); end
    $display("test_misalign done");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    mem[3] = 32'h33333333;
    mem[4] = 32'hDEADBEEF;
    test_reset();
    test_single_load();
    test_contention();
    test_store_then_load();
    test_back_to_back();
    test_reset_mid();
    test_wstrb_zero();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters.
- Requester 0 is the CPU datapath load/store port.
- Requester 1 is the debug/loader port, used by bench or boot logic to preload memory and read status words such as the PASS signature.
- Arbitration is fixed priority to the CPU, with a starvation guard. Read responses arrive one cycle after grant and are steered back to the owning requester. A stall output holds the CPU while it is denied.

Parameters:
- ADDR_WIDTH, 32, byte-address width on both requesters and the memory side.
- STARVE_LIMIT, 4, consecutive denied cycles of requester 1 before it takes priority; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- m0_req  in  1  CPU access request; held until m0_gnt
- m0_we  in  1  1=store, 0=load
- m0_addr  in  ADDR_WIDTH  CPU byte address
- m0_wdata  in  32  CPU store data
- m0_wstrb  in  4  CPU byte enables
- m0_gnt  out  1  CPU access accepted this cycle
- m0_rvalid  out  1  CPU load data valid
- m0_rdata  out  32  CPU load data
- m0_stall  out  1  m0_req & ~m0_gnt; CPU must freeze its PC
- m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb  in  1/1/ADDR_WIDTH/32/4  debug-side equivalents of the m0 inputs
- m1_gnt, m1_rvalid, m1_rdata  out  1/1/32  debug-side equivalents of the m0 outputs
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rdata  in  32  read data, valid the cycle after mem_en & ~mem_we
- err  out  1  misaligned access flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (reset==0 at posedge):
  - registered outputs m0_rvalid, m1_rvalid, err clear to 0.
  - starve_cnt and rd_owner clear to 0; resp_pending clears to 0.
  - combinational outputs m0_gnt, m1_gnt, mem_en are forced to 0 while reset is low.
- Grant is combinational, at most one requester per cycle:
  - pri1 = (starve_cnt == STARVE_LIMIT).
  - If pri1 & m1_req: grant m1. Else if m0_req: grant m0. Else if m1_req: grant m1. Else idle.
- Memory drive:
  - mem_en = m0_gnt | m1_gnt.
  - mem_we/addr/wdata/wstrb are muxed from the granted requester.
  - When idle, mem_we=0 and mem_wstrb=0.
  - A store whose wstrb is 0 is still granted and issued.
- Starvation counter (4-bit):
  - Increments when m1_req & ~m1_gnt.
  - Clears on m1_gnt or ~m1_req.
  - Saturates at STARVE_LIMIT.
- Read response:
  - On a granted load, register rd_owner = granted index and resp_pending = 1.
  - Next cycle: that owner's rvalid=1 and rdata=mem_rdata. The other rvalid stays 0.
  - Stores produce no rvalid.
- Back-to-back:
  - A new grant may occur in the same cycle a response is delivered.
  - Throughput is one access per cycle; load latency is exactly 1 cycle after gnt.
- rdata of a non-owner, or of any requester when rvalid=0, holds its last value.
- A request may be dropped by its requester before grant; no state is left behind.
- Reset asserted with resp_pending=1: the pending response is discarded, no rvalid is issued, and the memory write already performed stands.

Optional Feature:
- Macro: DMEM_ARB_MISALIGN_CHK_EN.
- With the macro defined:
  - A granted access is misaligned if addr[1:0] != 0 and wstrb is not contained in one word lane pattern. For loads, misaligned means addr[1:0] != 0.
  - The access is still granted but suppressed: mem_en=0 and mem_we=0.
  - err pulses 1 for one cycle, in the cycle after the grant.
  - A misaligned load returns rvalid with rdata=32'h0.
- Without the macro: no checking, err is tied 0, and every access goes to memory unchanged.

Test Plan:
- Single CPU load: m0_req=1, we=0, addr=0x10, mem_rdata=0xDEADBEEF. Expect m0_gnt in cycle 0, mem_en=1 and mem_addr=0x10, then m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle 1, and m1_rvalid=0.
- Contention: m0_req and m1_req held high continuously, STARVE_LIMIT=4. Expect m0 granted 4 cycles, then m1 granted in cycle 4, m0_stall=1 in that cycle only, and the pattern repeating every 5 cycles.
- Debug store then CPU load: m1 writes 0xC0DECAFE to addr 0x0 with wstrb=0xF; m0 then loads 0x0. Expect mem_we=1 in the grant cycle, and m0_rdata=0xC0DECAFE one cycle after m0_gnt.
- Back-to-back loads: m0 loads 0x4, 0x8, 0xC on consecutive cycles. Expect three m0_rvalid pulses on consecutive cycles with data in order, and m0_stall=0 throughout.
- Reset mid-operation: assert reset=0 in the cycle after a m1 load grant. Expect no m1_rvalid, and all outputs 0 at the next posedge.
- Misaligned store, with DMEM_ARB_MISALIGN_CHK_EN defined: m0 stores to addr=0x2 with wstrb=0xF. Expect m0_gnt=1, mem_en=0, and err=1 for exactly one cycle. Without the macro: mem_en=1 and err=0.
